spi_module_slave: RTL and testbench

- SPI responder for the opposite end of spi_module_master's bus.
- Oversamples spi_clk, spi_cs and spi_mosi in the system clock domain.
- Shifts received bits into spi_rx_data and drives spi_miso from a byte loaded from spi_tx_data.
- Used as the on-chip peer for master loopback and as the FPGA-side target when an external controller drives the bus.

---
 rtl/spi_pkg.sv | 21 ++
 rtl/spi_sync_edge.sv | 35 +++
 rtl/spi_module_slave.sv | 174 +++++++++++++++++
 tb/tb_spi_module_slave.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared definitions for the SPI responder.
//   SPI_DATA_W     : default frame width (bits per byte, MSB first)
//   state_t        : frame-level FSM states
//   sample_on_rise : whether the sample edge is the rising SCK edge for a mode
package spi_pkg;

    localparam int SPI_DATA_W = 8;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_t;

    // The leading edge moves SCK away from CPOL. CPHA=0 samples on the leading
    // edge and CPHA=1 on the trailing edge, so the sample edge is the rising
    // edge exactly when CPOL and CPHA agree.
    function automatic bit sample_on_rise(input bit cpol, input bit cpha);
        return (cpol == cpha);
    endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchronizer with edge-detect pulses for one asynchronous input.
//   clk, rst : system clock, asynchronous active-high reset
//   d_i      : asynchronous input pin
//   rise_o   : one-clk pulse when the synchronized level goes 0 -> 1
//   fall_o   : one-clk pulse when the synchronized level goes 1 -> 0
// STAGES must be at least 2. RST_VAL is the idle level of the line, so that
// releasing reset on an idle bus produces no spurious edge.
module spi_sync_edge #(
    parameter int STAGES  = 2,
    parameter bit RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic rise_o,
    output logic fall_o
);

    logic [STAGES-1:0] sync_q;
    logic              prev_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= {STAGES{RST_VAL}};
            prev_q <= RST_VAL;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
            prev_q <= sync_q[STAGES-1];
        end
    end

    assign rise_o = sync_q[STAGES-1] & ~prev_q;
    assign fall_o = ~sync_q[STAGES-1] & prev_q;

endmodule

// File: rtl/spi_module_slave.sv
// SPI responder, oversampling SCK/CS/MOSI in the system clock domain.
//   clk, rst     : system clock (>= 8x SCK), asynchronous active-high reset
//   spi_clk      : SCK from the master
//   spi_cs       : chip select, active-low
//   spi_mosi     : serial data from the master
//   spi_miso     : serial data to the master
//   spi_miso_oe  : MISO output enable, high while a frame is active
//   spi_tx_data  : byte to send, loaded at frame start and at byte boundaries
//   spi_rx_data  : last complete received byte
//   payload_done : one-clk pulse when spi_rx_data updates
//   frame_err    : one-clk pulse when CS rises with a partial byte
//   busy         : high from CS-fall detection to CS-rise detection
module spi_module_slave
    import spi_pkg::*;
#(
    parameter bit CPOL        = 1'b0,
    parameter bit CPHA        = 1'b0,
    parameter int DATA_W      = SPI_DATA_W,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              spi_clk,
    input  logic              spi_cs,
    input  logic              spi_mosi,
    output logic              spi_miso,
    output logic              spi_miso_oe,
    input  logic [DATA_W-1:0] spi_tx_data,
    output logic [DATA_W-1:0] spi_rx_data,
    output logic              payload_done,
    output logic              frame_err,
    output logic              busy
);

    localparam int CNT_W       = $clog2(DATA_W + 1);
    localparam bit SAMPLE_RISE = sample_on_rise(CPOL, CPHA);

    logic sck_rise, sck_fall, cs_rise, cs_fall;
    logic sample_edge, shift_edge, mosi_s;

    spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(CPOL)) u_sck_sync (
        .clk    (clk),
        .rst    (rst),
        .d_i    (spi_clk),
        .rise_o (sck_rise),
        .fall_o (sck_fall)
    );

    spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_cs_sync (
        .clk    (clk),
        .rst    (rst),
        .d_i    (spi_cs),
        .rise_o (cs_rise),
        .fall_o (cs_fall)
    );

    // MOSI runs through the same depth as SCK's synchronizer output, so the
    // data bit seen here lines up with the detected SCK edge.
    logic [SYNC_STAGES-1:0] mosi_sync_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) mosi_sync_q <= '0;
        else     mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi};
    end

    assign mosi_s      = mosi_sync_q[SYNC_STAGES-1];
    assign sample_edge = SAMPLE_RISE ? sck_rise : sck_fall;
    assign shift_edge  = SAMPLE_RISE ? sck_fall : sck_rise;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] tx_sr_q, tx_sr_d, rx_sr_q, rx_sr_d, rx_data_q, rx_data_d;
    logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic              miso_q, miso_d, oe_q, oe_d, busy_q, busy_d;
    logic              done_q, done_d, err_q, err_d;
    // CPHA=0 only: a shift edge is honoured only once a sample edge has been
    // seen since the last load, so the trailing edge right after a byte
    // boundary does not shift out the freshly loaded byte's MSB.
    logic              armed_q, armed_d;
    logic [DATA_W-1:0] rx_next;

    assign rx_next = {rx_sr_q[DATA_W-2:0], mosi_s};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            tx_sr_q   <= '0;
            rx_sr_q   <= '0;
            rx_data_q <= '0;
            bit_cnt_q <= '0;
            miso_q    <= 1'b0;
            oe_q      <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            armed_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            tx_sr_q   <= tx_sr_d;
            rx_sr_q   <= rx_sr_d;
            rx_data_q <= rx_data_d;
            bit_cnt_q <= bit_cnt_d;
            miso_q    <= miso_d;
            oe_q      <= oe_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            err_q     <= err_d;
            armed_q   <= armed_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        tx_sr_d   = tx_sr_q;
        rx_sr_d   = rx_sr_q;
        rx_data_d = rx_data_q;
        bit_cnt_d = bit_cnt_q;
        miso_d    = miso_q;
        oe_d      = oe_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        err_d     = 1'b0;
        armed_d   = armed_q;
        case (state_q)
            IDLE: begin
                if (cs_fall) begin
                    state_d   = ACTIVE;
                    tx_sr_d   = spi_tx_data;
                    bit_cnt_d = '0;
                    busy_d    = 1'b1;
                    oe_d      = 1'b1;
                    armed_d   = 1'b0;
                    miso_d    = CPHA ? 1'b0 : spi_tx_data[DATA_W-1];
                end
            end
            ACTIVE: begin
                // CS rise takes priority over a coincident sample edge.
                if (cs_rise) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    oe_d    = 1'b0;
                    miso_d  = 1'b0;
                    err_d   = (bit_cnt_q != '0);
                end else if (sample_edge) begin
                    rx_sr_d = rx_next;
                    if (bit_cnt_q == CNT_W'(DATA_W - 1)) begin
                        rx_data_d = rx_next;
                        done_d    = 1'b1;
                        bit_cnt_d = '0;
                        tx_sr_d   = spi_tx_data;
                        armed_d   = 1'b0;
                        if (!CPHA) miso_d = spi_tx_data[DATA_W-1];
                    end else begin
                        bit_cnt_d = bit_cnt_q + CNT_W'(1);
                        armed_d   = 1'b1;
                    end
                end else if (shift_edge && (CPHA || armed_q)) begin
                    // CPHA=0 already presented the MSB at the load point, so
                    // its shift edges present the next lower bit.
                    miso_d  = CPHA ? tx_sr_q[DATA_W-1] : tx_sr_q[DATA_W-2];
                    tx_sr_d = {tx_sr_q[DATA_W-2:0], 1'b0};
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign spi_miso     = miso_q;
    assign spi_miso_oe  = oe_q;
    assign spi_rx_data  = rx_data_q;
    assign payload_done = done_q;
    assign frame_err    = err_q;
    assign busy         = busy_q;

endmodule

// File: tb/tb_spi_module_slave.sv
module tb_spi_module_slave;

    localparam int H = 80;  // SCK half period in ns (clk period 10 ns)

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] sck, cs;
    logic       mosi;
    logic [3:0] miso, oe, done, err, busy;
    logic [7:0] txd [4];
    logic [7:0] rxd [4];

    always #5 clk = ~clk;

    // One responder per SPI mode: index m = {CPOL, CPHA}.
    for (genvar g = 0; g < 4; g++) begin : g_dut
        spi_module_slave #(
            .CPOL        (((g / 2) % 2) == 1),
            .CPHA        ((g % 2) == 1),
            .DATA_W      (8),
            .SYNC_STAGES (2)
        ) u_dut (
            .clk          (clk),
            .rst          (rst),
            .spi_clk      (sck[g]),
            .spi_cs       (cs[g]),
            .spi_mosi     (mosi),
            .spi_miso     (miso[g]),
            .spi_miso_oe  (oe[g]),
            .spi_tx_data  (txd[g]),
            .spi_rx_data  (rxd[g]),
            .payload_done (done[g]),
            .frame_err    (err[g]),
            .busy         (busy[g])
        );
    end

    int total = 0;
    int bad   = 0;
    int cur   = 0;
    int done_cnt [4] = '{0, 0, 0, 0};
    int err_cnt  [4] = '{0, 0, 0, 0};
    logic [7:0] rx_log [$];
    logic [7:0] mq [$];   // bytes the master sends
    logic [7:0] sq [$];   // bytes the responder is given to send
    logic [7:0] cap [$];  // bytes the master captured from MISO

    // Pulse monitor: counts every clk that payload_done / frame_err is high.
    always @(negedge clk) begin
        for (int k = 0; k < 4; k++) begin
            if (done[k] === 1'b1) begin
                done_cnt[k] <= done_cnt[k] + 1;
                if (k == cur) rx_log.push_back(rxd[k]);
            end
            if (err[k] === 1'b1) err_cnt[k] <= err_cnt[k] + 1;
        end
    end

    initial begin
        #3ms;
        $display("FAIL watchdog: observed=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Behavioural SPI master for mode m. Sends nbits from mq (MSB first),
    // captures MISO at each sample edge, and keeps the responder's
    // spi_tx_data one byte ahead (updated mid-byte). rst_at >= 0 asserts
    // reset just before bit index rst_at and abandons the frame.
    task automatic frame(input int m, input int nbits, input int rst_at);
        logic       c, p;
        logic [7:0] mb, cb;
        int         bi, bt;
        c  = (m / 2) == 1;
        p  = (m % 2) == 1;
        cb = 8'h00;
        cap.delete();
        @(negedge clk);
        txd[m] = (sq.size() > 0) ? sq[0] : 8'h00;
        cs[m]  = 1'b0;
        #H;
        check("busy_on", 32'(busy[m]), 32'd1);
        check("oe_on", 32'(oe[m]), 32'd1);
        for (int i = 0; i < nbits; i++) begin
            bi = i / 8;
            bt = 7 - (i % 8);
            mb = mq[bi];
            if (i == rst_at) begin
                rst = 1'b1;
                #1;
                check("rst_miso", 32'(miso[m]), 32'd0);
                check("rst_oe", 32'(oe[m]), 32'd0);
                check("rst_busy", 32'(busy[m]), 32'd0);
                check("rst_done_err", 32'({done[m], err[m]}), 32'd0);
                check("rst_rx", 32'(rxd[m]), 32'd0);
                cs[m]  = 1'b1;
                sck[m] = c;
                mosi   = 1'b0;
                repeat (3) @(negedge clk);
                rst = 1'b0;
                #(4 * H);
                return;
            end
            if ((i % 8) == 4) txd[m] = (sq.size() > bi + 1) ? sq[bi + 1] : 8'($urandom);
            if (!p) begin
                mosi = mb[bt];
                #H;
                sck[m] = ~c;
                cb = {cb[6:0], miso[m]};
                #H;
                sck[m] = c;
            end else begin
                #H;
                sck[m] = ~c;
                mosi   = mb[bt];
                #H;
                sck[m] = c;
                cb = {cb[6:0], miso[m]};
            end
            if ((i % 8) == 7) cap.push_back(cb);
        end
        #H;
        cs[m] = 1'b1;
        mosi  = 1'b0;
        #(4 * H);
    endtask

    // Frame of nb whole bytes plus part extra bits, checked against the
    // byte-level expectation: every whole byte is received and echoed,
    // a partial byte raises exactly one frame_err.
    task automatic run_frame(input int m, input int nb, input int part);
        int         d0, e0, l0;
        logic [7:0] old, got;
        cur = m;
        d0  = done_cnt[m];
        e0  = err_cnt[m];
        l0  = rx_log.size();
        old = rxd[m];
        frame(m, nb * 8 + part, -1);
        check("done_count", 32'(done_cnt[m] - d0), 32'(nb));
        check("err_count", 32'(err_cnt[m] - e0), (part != 0) ? 32'd1 : 32'd0);
        for (int b = 0; b < nb; b++) begin
            got = (l0 + b < rx_log.size()) ? rx_log[l0 + b] : 8'hxx;
            check("rx_byte", 32'(got), 32'(mq[b]));
            got = (b < cap.size()) ? cap[b] : 8'hxx;
            check("miso_byte", 32'(got), 32'(sq[b]));
        end
        if (nb == 0) check("rx_hold", 32'(rxd[m]), 32'(old));
        check("oe_off", 32'(oe[m]), 32'd0);
        check("busy_off", 32'(busy[m]), 32'd0);
        check("miso_off", 32'(miso[m]), 32'd0);
    endtask

    initial begin
        int d0s, e0s, nb;
        rst  = 1'b1;
        cs   = 4'hF;
        sck  = 4'b1100;
        mosi = 1'b0;
        for (int k = 0; k < 4; k++) txd[k] = 8'h00;
        repeat (3) @(negedge clk);
        check("in_reset_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_miso", 32'(miso), 32'd0);
        check("reset_oe", 32'(oe), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_err", 32'(err), 32'd0);
        for (int k = 0; k < 4; k++) check("reset_rx", 32'(rxd[k]), 32'd0);

        // Mode 0 loopback.
        mq.delete(); sq.delete();
        mq.push_back(8'hA5); sq.push_back(8'h3C);
        run_frame(0, 1, 0);
        check("loop_rx_port", 32'(rxd[0]), 32'h0A5);

        // Back-to-back bytes under one CS.
        mq.delete(); sq.delete();
        mq.push_back(8'h01); mq.push_back(8'h80); mq.push_back(8'hFF);
        sq.push_back(8'hC3); sq.push_back(8'h5A); sq.push_back(8'h96);
        run_frame(0, 3, 0);

        // Random multi-byte frames in every mode.
        for (int m = 0; m < 4; m++) begin
            for (int f = 0; f < 5; f++) begin
                nb = $urandom_range(1, 4);
                mq.delete(); sq.delete();
                for (int b = 0; b < nb; b++) begin
                    mq.push_back(8'($urandom));
                    sq.push_back(8'($urandom));
                end
                run_frame(m, nb, 0);
            end
        end

        // Aborted frames: 3 sample edges then CS rise.
        mq.delete(); sq.delete();
        mq.push_back(8'h6B); sq.push_back(8'h00);
        run_frame(0, 0, 3);
        run_frame(3, 0, 3);

        // Reset after 5 bits, then a clean 0x5A frame.
        mq.delete(); sq.delete();
        mq.push_back(8'hF0); sq.push_back(8'h11);
        cur = 0;
        d0s = done_cnt[0];
        e0s = err_cnt[0];
        frame(0, 8, 5);
        check("rst_no_done", 32'(done_cnt[0] - d0s), 32'd0);
        check("rst_no_err", 32'(err_cnt[0] - e0s), 32'd0);
        mq.delete(); sq.delete();
        mq.push_back(8'h5A); sq.push_back(8'hA7);
        run_frame(0, 1, 0);
        check("post_rst_rx", 32'(rxd[0]), 32'h05A);

        // SCK toggling with every CS high must be ignored.
        d0s = done_cnt[0] + done_cnt[1] + done_cnt[2] + done_cnt[3];
        e0s = err_cnt[0] + err_cnt[1] + err_cnt[2] + err_cnt[3];
        for (int t = 0; t < 16; t++) begin
            @(negedge clk);
            sck = ~sck;
            repeat (4) @(negedge clk);
            if (t % 4 == 3) begin
                check("idle_busy", 32'(busy), 32'd0);
                check("idle_oe", 32'(oe), 32'd0);
            end
        end
        repeat (8) @(negedge clk);
        check("idle_done", 32'(done_cnt[0] + done_cnt[1] + done_cnt[2] + done_cnt[3] - d0s), 32'd0);
        check("idle_err", 32'(err_cnt[0] + err_cnt[1] + err_cnt[2] + err_cnt[3] - e0s), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
